sram_ctrl: RTL

//  Parametrised single-port word RAM peripheral for the embedded SoC bus. Replaces
//  the tri-state shared-data RAM with split valid/ready request and response channels.

---
 rtl/sram_ctrl_if.sv | 29 ++
 rtl/sram_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sram_ctrl_if.sv
// Request/response bus for sram_ctrl: split valid/ready channels for requests and responses.
// The master drives requests and rsp_ready; the slave (the RAM) drives responses and req_ready.
interface sram_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port word RAM peripheral with byte-enable writes, a relocatable window,
// 1- or 2-cycle read latency and an in-order response FIFO sized to the credit limit.
module sram_ctrl #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
   parameter int unsigned       RD_LAT    = 1
) (
   input  logic       clk,
   input  logic       rst,
   sram_ctrl_if.slave bus
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CAP   = RD_LAT + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PTR_W = (CAP > 2) ? 2 : 1;
   localparam int unsigned CNT_W = $clog2(CAP + 1);
   localparam logic [ADDR_W-1:0] BE_W_A   = ADDR_W'(BE_W);
   localparam logic [ADDR_W:0]   SPAN_A   = (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(BE_W);
   localparam logic [CNT_W-1:0]  CAP_C    = CNT_W'(CAP);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(CAP - 1);

   if ((RD_LAT < 1) || (RD_LAT > 2)) begin : g_bad_lat
      $error("sram_ctrl: RD_LAT must be 1 or 2");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_width
      $error("sram_ctrl: DATA_W must be a multiple of 8");
   end

   logic [DATA_W-1:0] mem_q       [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [CAP];
   logic              fifo_err_q  [CAP];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, out_q, out_d;
   logic [ADDR_W-1:0] off_s;
   logic [IDX_W-1:0]  idx_s;
   logic [DATA_W-1:0] rsp_word_s, push_data_s;
   logic              hit_s, req_ready_s, accept_s, pop_s, rsp_valid_s;
   logic              push_valid_s, push_err_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   // Window decode; reads of misses and all writes respond with zero data.
   always_comb begin
      off_s      = bus.req_addr - BASE_ADDR;
      hit_s      = (bus.req_addr >= BASE_ADDR) && ({1'b0, off_s} < SPAN_A) &&
                   ((off_s % BE_W_A) == {ADDR_W{1'b0}});
      idx_s      = IDX_W'(off_s / BE_W_A);
      rsp_word_s = (hit_s && !bus.req_we) ? mem_q[idx_s] : {DATA_W{1'b0}};
   end

   assign req_ready_s = rst & (out_q < CAP_C);
   assign accept_s    = bus.req_valid & req_ready_s;
   assign rsp_valid_s = (cnt_q != {CNT_W{1'b0}});
   assign pop_s       = rsp_valid_s & bus.rsp_ready;

   // RAM array: byte-lane writes on accepted hits, contents survive reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (accept_s && bus.req_we && hit_s && bus.req_be[i]) begin
            mem_q[idx_s][8*i +: 8] <= bus.req_wdata[8*i +: 8];
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              st_valid_q, st_err_q;
      logic [DATA_W-1:0] st_data_q;

      // Extra register stage between the RAM read and the response FIFO.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            st_valid_q <= 1'b0;
            st_err_q   <= 1'b0;
            st_data_q  <= {DATA_W{1'b0}};
         end else begin
            st_valid_q <= accept_s;
            st_err_q   <= !hit_s;
            st_data_q  <= rsp_word_s;
         end
      end
      assign push_valid_s = st_valid_q;
      assign push_err_s   = st_err_q;
      assign push_data_s  = st_data_q;
   end else begin : g_lat1
      assign push_valid_s = accept_s;
      assign push_err_s   = !hit_s;
      assign push_data_s  = rsp_word_s;
   end

   // Next-state for FIFO pointers, occupancy and outstanding credit count.
   always_comb begin
      wr_ptr_d = push_valid_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_valid_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      case ({accept_s, pop_s})
         2'b10:   out_d = out_q + CNT_W'(1);
         2'b01:   out_d = out_q - CNT_W'(1);
         default: out_d = out_q;
      endcase
   end

   // Control state; reset drops every in-flight response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         out_q    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
      end
   end

   // FIFO payload storage; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_valid_s) begin
         fifo_data_q[wr_ptr_q] <= push_data_s;
         fifo_err_q[wr_ptr_q]  <= push_err_s;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_rdata = rsp_valid_s ? fifo_data_q[rd_ptr_q] : {DATA_W{1'b0}};
   assign bus.rsp_err   = rsp_valid_s & fifo_err_q[rd_ptr_q];
endmodule
